// File: rtl/mtp_access_arb_pkg.sv
// Shared definitions for the MTP access arbiter: state encoding, requester
// indices into the one-hot grant vector, and the default WAIT watchdog limit.
package mtp_pkg;

    // State encoding kept as plain constants so legacy code can compare raw bits.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_NEXT  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Named view of the same encoding, handy for debug and waveform decoding.
    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_ISSUE = ST_ISSUE,
        S_WAIT  = ST_WAIT,
        S_NEXT  = ST_NEXT,
        S_DONE  = ST_DONE
    } mtp_state_e;

    // Bit positions of each client in gnt = {ocu, par, init}.
    localparam int REQ_INIT = 0;
    localparam int REQ_PAR  = 1;
    localparam int REQ_OCU  = 2;

    // Cycles a word may sit in WAIT before the job is aborted.
    localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/mtp_access_arb_if.sv
// Client/engine-side bundle of the MTP access arbiter. The arbiter uses the
// slave view; clients and the memory engine (or a bench) use the master view.
interface mtp_access_arb_if #(
    parameter int AW = 6
);
    logic          init_req;
    logic          par_req;
    logic          ocu_req;
    logic [AW-1:0] init_ptr;
    logic [AW-1:0] par_ptr;
    logic [AW-1:0] ocu_ptr;
    logic [AW-1:0] init_len;
    logic [AW-1:0] par_len;
    logic [AW-1:0] ocu_len;
    logic          ocu_wr;
    logic          mtp_ready;
    logic          word_done;
    logic          rd_start;
    logic          wr_start;
    logic [AW-1:0] addr;
    logic [2:0]    gnt;
    logic          busy;
    logic          job_done;
    logic          job_err;
    logic [AW-1:0] word_idx;

    modport slave (
        input  init_req, par_req, ocu_req,
        input  init_ptr, par_ptr, ocu_ptr,
        input  init_len, par_len, ocu_len,
        input  ocu_wr, mtp_ready, word_done,
        output rd_start, wr_start, addr, gnt, busy, job_done, job_err, word_idx
    );

    modport master (
        output init_req, par_req, ocu_req,
        output init_ptr, par_ptr, ocu_ptr,
        output init_len, par_len, ocu_len,
        output ocu_wr, mtp_ready, word_done,
        input  rd_start, wr_start, addr, gnt, busy, job_done, job_err, word_idx
    );
endinterface

// File: rtl/mtp_word_timer.sv
// WAIT watchdog: 8-bit up counter with clear and enable; tc flags that the
// count has reached LIMIT.
module mtp_word_timer
    import mtp_pkg::*;
#(
    parameter logic [7:0] LIMIT = 8'(TIMEOUT_DEF)
) (
    input  logic rd_clock,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Next count: clear has priority, otherwise count while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 8'd0;
        end else if (en) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge rd_clock or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == LIMIT);

endmodule

// File: rtl/mtp_access_arb.sv
// MTP access arbiter: grants one whole job at a time (init > par > ocu),
// steps the engine one word per ISSUE/WAIT/NEXT loop and aborts a job whose
// word never completes. new_cmd synchronously returns everything to IDLE.
module mtp_access_arb
    import mtp_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_DEF,
    parameter int AW          = 6
) (
    input  logic              rd_clock,
    input  logic              rst_n,
    input  logic              new_cmd,
    mtp_access_arb_if.slave   bus
);

    logic [2:0]    state_q,    state_d;
    logic [AW-1:0] ptr_q,      ptr_d;
    logic [AW-1:0] len_q,      len_d;
    logic          wr_q,       wr_d;
    logic [AW-1:0] addr_q,     addr_d;
    logic [AW-1:0] word_idx_q, word_idx_d;
    logic [2:0]    gnt_q,      gnt_d;
    logic          rd_start_q, rd_start_d;
    logic          wr_start_q, wr_start_d;
    logic          busy_q,     busy_d;
    logic          job_done_q, job_done_d;
    logic          job_err_q,  job_err_d;

    logic [2:0]    sel_gnt_s;
    logic [AW-1:0] sel_ptr_s;
    logic [AW-1:0] sel_len_s;
    logic          sel_wr_s;
    logic [AW-1:0] nxt_idx_s;
    logic          tmr_clr_s;
    logic          tmr_en_s;
    logic          tmr_tc_s;

    // Fixed-priority pick of the winning client and its job description.
    always_comb begin
        sel_gnt_s = 3'b000;
        sel_ptr_s = '0;
        sel_len_s = '0;
        sel_wr_s  = 1'b0;
        if (bus.init_req) begin
            sel_gnt_s[REQ_INIT] = 1'b1;
            sel_ptr_s           = bus.init_ptr;
            sel_len_s           = bus.init_len;
        end else if (bus.par_req) begin
            sel_gnt_s[REQ_PAR] = 1'b1;
            sel_ptr_s          = bus.par_ptr;
            sel_len_s          = bus.par_len;
        end else if (bus.ocu_req) begin
            sel_gnt_s[REQ_OCU] = 1'b1;
            sel_ptr_s          = bus.ocu_ptr;
            sel_len_s          = bus.ocu_len;
            sel_wr_s           = bus.ocu_wr;
        end else begin
            sel_gnt_s = 3'b000;
        end
    end

    // The watchdog only runs while a word is outstanding.
    assign tmr_en_s  = (state_q == ST_WAIT);
    assign tmr_clr_s = new_cmd || (state_q != ST_WAIT);

    mtp_word_timer #(
        .LIMIT (8'(TIMEOUT_CYC))
    ) u_word_timer (
        .rd_clock (rd_clock),
        .rst_n    (rst_n),
        .clr      (tmr_clr_s),
        .en       (tmr_en_s),
        .tc       (tmr_tc_s)
    );

    // Job sequencer; job_done/job_err are raised on entry to DONE so they
    // are visible during the DONE cycle itself.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        len_d      = len_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        word_idx_d = word_idx_q;
        gnt_d      = gnt_q;
        rd_start_d = 1'b0;
        wr_start_d = 1'b0;
        job_done_d = 1'b0;
        job_err_d  = 1'b0;
        nxt_idx_s  = word_idx_q + AW'(1);

        if (new_cmd) begin
            state_d    = ST_IDLE;
            addr_d     = '0;
            word_idx_d = '0;
            gnt_d      = 3'b000;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (sel_gnt_s != 3'b000) begin
                        ptr_d      = sel_ptr_s;
                        len_d      = sel_len_s;
                        wr_d       = sel_wr_s;
                        word_idx_d = '0;
                        gnt_d      = sel_gnt_s;
                        if (sel_len_s == '0) begin
                            state_d    = ST_DONE;
                            job_done_d = 1'b1;
                        end else begin
                            state_d = ST_ISSUE;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    // Address wraps naturally at 2^AW.
                    addr_d = ptr_q + word_idx_q;
                    if (!wr_q) begin
                        rd_start_d = 1'b1;
                        state_d    = ST_WAIT;
                    end else if (bus.mtp_ready) begin
                        wr_start_d = 1'b1;
                        state_d    = ST_WAIT;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
                ST_WAIT: begin
                    if (bus.word_done) begin
                        state_d = ST_NEXT;
                    end else if (tmr_tc_s) begin
                        state_d    = ST_DONE;
                        job_done_d = 1'b1;
                        job_err_d  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_NEXT: begin
                    word_idx_d = nxt_idx_s;
                    if (nxt_idx_s == len_q) begin
                        state_d    = ST_DONE;
                        job_done_d = 1'b1;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
                ST_DONE: begin
                    gnt_d   = 3'b000;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    gnt_d   = 3'b000;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State, job context and registered outputs.
    always_ff @(posedge rd_clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            len_q      <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            word_idx_q <= '0;
            gnt_q      <= 3'b000;
            rd_start_q <= 1'b0;
            wr_start_q <= 1'b0;
            busy_q     <= 1'b0;
            job_done_q <= 1'b0;
            job_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            len_q      <= len_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            word_idx_q <= word_idx_d;
            gnt_q      <= gnt_d;
            rd_start_q <= rd_start_d;
            wr_start_q <= wr_start_d;
            busy_q     <= busy_d;
            job_done_q <= job_done_d;
            job_err_q  <= job_err_d;
        end
    end

    assign bus.rd_start = rd_start_q;
    assign bus.wr_start = wr_start_q;
    assign bus.addr     = addr_q;
    assign bus.gnt      = gnt_q;
    assign bus.busy     = busy_q;
    assign bus.job_done = job_done_q;
    assign bus.job_err  = job_err_q;
    assign bus.word_idx = word_idx_q;

endmodule

// File: tb/tb_mtp_access_arb.sv
// Bench for mtp_access_arb: directed job table, hand-written multi-cycle
// sequences and randomized single-client jobs against a job-level timing model.
module tb_mtp_access_arb;
    import mtp_pkg::*;

    localparam int AW   = 6;
    localparam int TO   = 255;
    localparam int MAXC = 1024;

    logic rd_clock = 1'b0;
    logic rst_n;
    logic new_cmd;

    mtp_access_arb_if #(.AW(AW)) bus();

    mtp_access_arb #(.TIMEOUT_CYC(TO), .AW(AW)) dut (
        .rd_clock (rd_clock),
        .rst_n    (rst_n),
        .new_cmd  (new_cmd),
        .bus      (bus.slave)
    );

    always #5 rd_clock = ~rd_clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Engine responder and stimulus shaping
    int  wd_dly [64];     // WAIT cycles per word; 0 = word_done withheld
    bit  rdy_pat [MAXC];  // mtp_ready per cycle of a job
    bit  stray_en;
    int  eng_cnt;
    bit  eng_out;
    int  eng_widx;

    // Observations of the last run_job
    int          obs_nstb;
    int          obs_done_t;
    int          obs_err;
    logic [2:0]  obs_gnt0;
    logic [5:0]  obs_addr [3];

    typedef struct {
        int         which;
        logic [5:0] ptr;
        logic [5:0] len;
        bit         wr;
        int         dly;
        int         stall;
        logic [2:0] e_gnt;
        int         e_nstb;
        logic [5:0] e_a0, e_a1, e_a2;
        int         e_done;
        bit         e_err;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge rd_clock);
        #1;
    endtask

    task automatic set_req(input int which, input bit v);
        case (which)
            REQ_INIT: bus.init_req = v;
            REQ_PAR:  bus.par_req  = v;
            REQ_OCU:  bus.ocu_req  = v;
            default:  ;
        endcase
    endtask

    task automatic engine_reset();
        eng_cnt = 0;
        eng_out = 1'b0;
        eng_widx = 0;
        bus.word_done = 1'b0;
    endtask

    // One engine step per cycle: answer each strobe after its programmed delay.
    task automatic engine();
        bus.word_done = 1'b0;
        if (bus.rd_start || bus.wr_start) begin
            eng_out = 1'b1;
            eng_cnt = (eng_widx < 64) ? wd_dly[eng_widx] : 1;
            eng_widx++;
        end
        if (eng_out && eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                bus.word_done = 1'b1;
                eng_out = 1'b0;
            end
        end else if (!eng_out && stray_en && $urandom_range(0, 3) == 0) begin
            bus.word_done = 1'b1;
        end
    endtask

    // Run one job from a single client; expected behaviour is derived from
    // the job description: per word, stall until ready, strobe, n WAIT cycles,
    // one NEXT cycle; timeout ends the job TO+1 cycles after a strobe.
    task automatic run_job(input int which, input logic [5:0] ptr, input logic [5:0] len, input bit wr_in);
        bit         wr_eff;
        bit         is_stb [MAXC];
        logic [5:0] stb_addr [MAXC];
        int         t, tdone, words;
        bit         err;
        logic [2:0] gnt_exp;
        logic [7:0] ev, av;

        wr_eff = (which == REQ_OCU) && wr_in;
        for (int c = 0; c < MAXC; c++) begin
            is_stb[c] = 1'b0;
            stb_addr[c] = 6'd0;
        end
        t = 0; tdone = 0; words = 0; err = 1'b0;
        for (int i = 0; i < int'(len); i++) begin
            while (wr_eff && !rdy_pat[t] && t < MAXC - 300) t++;
            is_stb[t + 1] = 1'b1;
            stb_addr[t + 1] = 6'(int'(ptr) + i);
            if (wd_dly[i] == 0) begin
                err = 1'b1;
                tdone = t + 1 + TO + 1;
                break;
            end
            t = t + 1 + wd_dly[i] + 1;
            words = i + 1;
        end
        if (!err) tdone = t;
        gnt_exp = 3'b001 << which;

        bus.init_ptr = 6'($urandom); bus.par_ptr = 6'($urandom); bus.ocu_ptr = 6'($urandom);
        bus.init_len = 6'($urandom); bus.par_len = 6'($urandom); bus.ocu_len = 6'($urandom);
        bus.ocu_wr   = (which == REQ_OCU) ? wr_in : 1'($urandom);
        case (which)
            REQ_INIT: begin bus.init_ptr = ptr; bus.init_len = len; end
            REQ_PAR:  begin bus.par_ptr  = ptr; bus.par_len  = len; end
            default:  begin bus.ocu_ptr  = ptr; bus.ocu_len  = len; end
        endcase
        engine_reset();
        obs_nstb = 0; obs_done_t = -1; obs_err = 0; obs_gnt0 = 3'b000;
        set_req(which, 1'b1);

        for (int c = 0; c <= tdone + 2; c++) begin
            tick();
            ev = {is_stb[c] && !wr_eff, is_stb[c] && wr_eff,
                  (c <= tdone) ? gnt_exp : 3'b000, (c <= tdone), (c == tdone), (c == tdone) && err};
            av = {bus.rd_start, bus.wr_start, bus.gnt, bus.busy, bus.job_done, bus.job_err};
            chk("cycle_flags", 32'(av), 32'(ev));
            if (is_stb[c]) chk("strobe_addr", 32'(bus.addr), 32'(stb_addr[c]));
            if (c == tdone) chk("word_idx_at_done", 32'(bus.word_idx), 32'(words));
            if (bus.rd_start || bus.wr_start) begin
                if (obs_nstb < 3) obs_addr[obs_nstb] = bus.addr;
                obs_nstb++;
            end
            if (bus.job_done && obs_done_t < 0) begin
                obs_done_t = c;
                obs_err = int'(bus.job_err);
            end
            if (c == 0) begin
                obs_gnt0 = bus.gnt;
                bus.init_ptr = 6'($urandom); bus.par_ptr = 6'($urandom); bus.ocu_ptr = 6'($urandom);
                bus.init_len = 6'($urandom); bus.par_len = 6'($urandom); bus.ocu_len = 6'($urandom);
                bus.ocu_wr   = 1'($urandom);
            end
            if (bus.job_done || c >= tdone) begin
                set_req(which, 1'b0);
                eng_out = 1'b0;
                eng_cnt = 0;
            end
            bus.mtp_ready = rdy_pat[c];
            engine();
        end
        bus.mtp_ready = 1'b1;
    endtask

    initial begin
        int         gseq [3];
        int         gcyc [3];
        int         ng, nd, nstb, first_a, done_seen;
        logic [2:0] prev;

        rst_n = 1'b0; new_cmd = 1'b0; stray_en = 1'b0;
        bus.init_req = 1'b0; bus.par_req = 1'b0; bus.ocu_req = 1'b0;
        bus.init_ptr = 6'd0; bus.par_ptr = 6'd0; bus.ocu_ptr = 6'd0;
        bus.init_len = 6'd0; bus.par_len = 6'd0; bus.ocu_len = 6'd0;
        bus.ocu_wr = 1'b0; bus.mtp_ready = 1'b1; bus.word_done = 1'b0;
        for (int i = 0; i < 64; i++) wd_dly[i] = 1;
        for (int c = 0; c < MAXC; c++) rdy_pat[c] = 1'b1;

        // Reset state
        repeat (3) tick();
        chk("reset_outputs", 32'({bus.rd_start, bus.wr_start, bus.addr, bus.gnt, bus.busy,
                                  bus.job_done, bus.job_err, bus.word_idx}), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_after_reset", 32'({bus.gnt, bus.busy}), 32'd0);

        // Directed job table: {client, ptr, len, wr, dly, stall} -> expectations
        tbl[0] = '{REQ_INIT, 6'd5,  6'd3,  1'b0, 3, 0, 3'b001, 3,  6'd5,  6'd6,  6'd7, 15,  1'b0};
        tbl[1] = '{REQ_OCU,  6'd62, 6'd3,  1'b1, 1, 5, 3'b100, 3,  6'd62, 6'd63, 6'd0, 14,  1'b0};
        tbl[2] = '{REQ_PAR,  6'd9,  6'd0,  1'b0, 1, 0, 3'b010, 0,  6'd0,  6'd0,  6'd0, 0,   1'b0};
        tbl[3] = '{REQ_PAR,  6'd10, 6'd1,  1'b0, 1, 0, 3'b010, 1,  6'd10, 6'd0,  6'd0, 3,   1'b0};
        tbl[4] = '{REQ_INIT, 6'd0,  6'd2,  1'b0, 0, 0, 3'b001, 1,  6'd0,  6'd0,  6'd0, 257, 1'b1};
        tbl[5] = '{REQ_OCU,  6'd63, 6'd2,  1'b0, 2, 0, 3'b100, 2,  6'd63, 6'd0,  6'd0, 8,   1'b0};
        tbl[6] = '{REQ_OCU,  6'd1,  6'd63, 1'b0, 1, 0, 3'b100, 63, 6'd1,  6'd2,  6'd3, 189, 1'b0};

        for (int k = 0; k < 7; k++) begin
            logic [5:0] ea [3];
            ea[0] = tbl[k].e_a0; ea[1] = tbl[k].e_a1; ea[2] = tbl[k].e_a2;
            for (int i = 0; i < 64; i++) wd_dly[i] = tbl[k].dly;
            for (int c = 0; c < MAXC; c++) rdy_pat[c] = (c >= tbl[k].stall);
            stray_en = 1'b0;
            run_job(tbl[k].which, tbl[k].ptr, tbl[k].len, tbl[k].wr);
            chk("tbl_gnt", 32'(obs_gnt0), 32'(tbl[k].e_gnt));
            chk("tbl_nstrobe", 32'(obs_nstb), 32'(tbl[k].e_nstb));
            for (int a = 0; a < 3; a++)
                if (a < tbl[k].e_nstb) chk("tbl_addr", 32'(obs_addr[a]), 32'(ea[a]));
            chk("tbl_done_cycle", 32'(obs_done_t), 32'(tbl[k].e_done));
            chk("tbl_err", 32'(obs_err), 32'(tbl[k].e_err));
        end

        // All three clients request together: served init, par, ocu in turn
        for (int i = 0; i < 64; i++) wd_dly[i] = 1;
        for (int c = 0; c < MAXC; c++) rdy_pat[c] = 1'b1;
        bus.init_ptr = 6'd0;  bus.init_len = 6'd1;
        bus.par_ptr  = 6'd8;  bus.par_len  = 6'd1;
        bus.ocu_ptr  = 6'd16; bus.ocu_len  = 6'd1; bus.ocu_wr = 1'b0;
        engine_reset();
        bus.init_req = 1'b1; bus.par_req = 1'b1; bus.ocu_req = 1'b1;
        ng = 0; nd = 0; prev = 3'b000;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (bus.gnt != 3'b000 && prev == 3'b000) begin
                if (ng < 3) begin
                    gseq[ng] = int'(bus.gnt);
                    gcyc[ng] = c;
                    chk("done_before_grant", 32'(nd), 32'(ng));
                end
                ng++;
            end
            prev = bus.gnt;
            if (bus.job_done) begin
                nd++;
                if (bus.gnt[REQ_INIT]) bus.init_req = 1'b0;
                if (bus.gnt[REQ_PAR])  bus.par_req  = 1'b0;
                if (bus.gnt[REQ_OCU])  bus.ocu_req  = 1'b0;
                eng_out = 1'b0;
            end
            engine();
        end
        bus.init_req = 1'b0; bus.par_req = 1'b0; bus.ocu_req = 1'b0;
        chk("multi_grants", 32'(ng), 32'd3);
        chk("multi_dones", 32'(nd), 32'd3);
        if (ng >= 3) begin
            chk("multi_gnt0", 32'(gseq[0]), 32'b001);
            chk("multi_gnt1", 32'(gseq[1]), 32'b010);
            chk("multi_gnt2", 32'(gseq[2]), 32'b100);
            chk("multi_cyc1", 32'(gcyc[1]), 32'd5);
            chk("multi_cyc2", 32'(gcyc[2]), 32'd10);
        end

        // new_cmd during WAIT of the second word of a 4-word job
        for (int i = 0; i < 64; i++) wd_dly[i] = 1;
        wd_dly[1] = 20;
        bus.init_ptr = 6'd20; bus.init_len = 6'd4;
        engine_reset();
        stray_en = 1'b0;
        bus.init_req = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            tick();
            if (c == 4) chk("abort_pre_strobe", 32'({bus.rd_start, bus.addr}), 32'({1'b1, 6'd21}));
            engine();
        end
        new_cmd = 1'b1;
        bus.init_req = 1'b0;
        tick();
        new_cmd = 1'b0;
        chk("abort_outputs_zero", 32'({bus.rd_start, bus.wr_start, bus.addr, bus.gnt, bus.busy,
                                       bus.job_done, bus.job_err, bus.word_idx}), 32'd0);
        engine_reset();
        nd = 0; ng = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (bus.job_done) nd++;
            if (bus.gnt != 3'b000) ng++;
            engine();
        end
        chk("abort_no_job_done", 32'(nd), 32'd0);
        chk("abort_stays_idle", 32'(ng), 32'd0);
        for (int i = 0; i < 64; i++) wd_dly[i] = 1;
        bus.init_req = 1'b1;
        tick();
        chk("restart_gnt", 32'(bus.gnt), 32'b001);
        chk("restart_word_idx", 32'(bus.word_idx), 32'd0);
        engine();
        nstb = 0; first_a = -1; done_seen = 0;
        for (int c = 0; c < 40 && done_seen == 0; c++) begin
            tick();
            if (bus.rd_start) begin
                if (first_a < 0) first_a = int'(bus.addr);
                nstb++;
            end
            if (bus.job_done) begin
                done_seen = 1;
                bus.init_req = 1'b0;
            end
            engine();
        end
        bus.init_req = 1'b0;
        chk("restart_done_seen", 32'(done_seen), 32'd1);
        chk("restart_first_addr", 32'(first_a), 32'd20);
        chk("restart_nstrobe", 32'(nstb), 32'd4);
        repeat (2) tick();

        // Randomized single-client jobs with stalls, stray word_done and rare timeouts
        for (int j = 0; j < 25; j++) begin
            int         which;
            logic [5:0] ptr, len;
            bit         wr;
            which = $urandom_range(0, 2);
            ptr   = 6'($urandom);
            len   = 6'($urandom_range(0, 10));
            wr    = 1'($urandom_range(0, 1));
            for (int i = 0; i < 64; i++)
                wd_dly[i] = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 4);
            for (int c = 0; c < MAXC; c++) rdy_pat[c] = ($urandom_range(0, 2) != 0);
            stray_en = 1'b1;
            run_job(which, ptr, len, wr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
